alu_arbiter: RTL

- Shares one `alu` instance between two requesters.
- Per-cycle round-robin arbitration; pipelined issue, up to one op per clock.
- Drives the ALU operand and mode pins, tracks in-flight ops with a tagged valid pipeline, and returns each result to its owner.
- Halt/drain control lets the system quiesce the ALU, e.g. before reconfiguration or test.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_pick.sv | 34 +++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared encodings and pipeline types for the ALU arbiter
package alu_arbiter_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;

    // ALU operand register plus result register; one extra stage lines up rsp capture
    localparam int ALU_LAT = 2;
    localparam int PIPE_D  = ALU_LAT + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic       v;
        logic       tag;
        logic [1:0] mode;
    } stage_t;

endpackage

// File: rtl/alu_arbiter_pick.sv
// rtl/alu_arbiter_pick.sv - rr_pick2: two-requester round-robin picker, one-hot combinational grant
module rr_pick2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        ptr_d = ptr_q;
        if (gnt[0]) ptr_d = 1'b1;
        else if (gnt[1]) ptr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!ar) ptr_q <= RR_INIT;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters; ALU_ARB_STATS_EN adds grant/wait counters
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int STAT_W  = 16,
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       ar,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [1:0] mode0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [1:0] mode1,
    input  logic       halt,
    output logic       idle,
    output logic [1:0] rsp_valid,
    output logic [7:0] rsp_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_mode,
    input  logic [7:0] alu_sc
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1,
    output logic [STAT_W-1:0] wait_cnt0,
    output logic [STAT_W-1:0] wait_cnt1
`endif
);

    if (STAT_W < 1) begin : g_bad_stat_w
        $error("STAT_W must be at least 1");
    end

    state_e                  state_q, state_d;
    logic                    idle_q, idle_d;
    stage_t [PIPE_D-1:0]     stage_q, stage_d;
    logic [3:0]              alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]              alu_mode_q, alu_mode_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_data_q, rsp_data_d;
    logic                    pick_en, pipe_busy;

    // Reset and halt both mask grants so the pointer only moves on real issues
    assign pick_en = ar && (state_q == RUN) && !halt;

    rr_pick2 #(.RR_INIT(RR_INIT)) u_pick (
        .clk (clk),
        .ar  (ar),
        .en  (pick_en),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_mode_d  = alu_mode_q;
        rsp_data_d  = rsp_data_q;
        stage_d[0]  = '{v: |gnt, tag: gnt[1], mode: gnt[1] ? mode1 : mode0};
        for (int i = 1; i < PIPE_D; i++) stage_d[i] = stage_q[i-1];
        if (|gnt) begin
            alu_a_d = gnt[1] ? a1 : a0;
            alu_b_d = gnt[1] ? b1 : b0;
        end
        // Mode lags operands by one stage to match the ALU's internal operand register
        if (stage_q[0].v) alu_mode_d = stage_q[0].mode;
        rsp_valid_d = 2'b00;
        if (stage_q[PIPE_D-1].v) begin
            rsp_valid_d = stage_q[PIPE_D-1].tag ? 2'b10 : 2'b01;
            rsp_data_d  = alu_sc;
        end

        pipe_busy = |rsp_valid_q;
        for (int i = 0; i < PIPE_D; i++) pipe_busy = pipe_busy | stage_q[i].v;
        state_d = state_q;
        unique case (state_q)
            RUN:     if (halt) state_d = DRAIN;
            DRAIN:   if (!halt) state_d = RUN;
                     else if (!pipe_busy) state_d = HALTED;
            HALTED:  if (!halt) state_d = RUN;
            default: state_d = RUN;
        endcase
        idle_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (!ar) begin
            state_q     <= RUN;
            idle_q      <= 1'b0;
            stage_q     <= '0;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            alu_mode_q  <= MODE_ADD;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            stage_q     <= stage_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_mode_q  <= alu_mode_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign idle      = idle_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] gnt_cnt_q  [2];
    logic [STAT_W-1:0] gnt_cnt_d  [2];
    logic [STAT_W-1:0] wait_cnt_q [2];
    logic [STAT_W-1:0] wait_cnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gnt_cnt_d[i]  = gnt_cnt_q[i];
            wait_cnt_d[i] = wait_cnt_q[i];
            if (stat_clr) begin
                gnt_cnt_d[i]  = '0;
                wait_cnt_d[i] = '0;
            end else begin
                if (gnt[i] && !(&gnt_cnt_q[i]))
                    gnt_cnt_d[i] = gnt_cnt_q[i] + STAT_W'(1);
                if (req[i] && !gnt[i] && !(&wait_cnt_q[i]))
                    wait_cnt_d[i] = wait_cnt_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ar) begin
                gnt_cnt_q[i]  <= '0;
                wait_cnt_q[i] <= '0;
            end else begin
                gnt_cnt_q[i]  <= gnt_cnt_d[i];
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign gnt_cnt0  = gnt_cnt_q[0];
    assign gnt_cnt1  = gnt_cnt_q[1];
    assign wait_cnt0 = wait_cnt_q[0];
    assign wait_cnt1 = wait_cnt_q[1];
`endif

endmodule
